glyph_rom_arbiter: RTL and testbench

//  Shares one synchronous-read glyph ROM (128 x 8, {digit,yofs} address) between two requesters.

---
 rtl/glyph_rom_arbiter.sv | 123 ++++++++++++
 tb/tb_glyph_rom_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_rom_arbiter.sv
// Two-port arbiter in front of a 128 x 8 synchronous-read glyph ROM.
// Port 0 (pixel renderer) normally wins. Port 1 (overlay/debug reader) is
// forced through after MAX_STARVE consecutive lost cycles. Each accepted
// read returns two clocks later on the port that issued it, in order.
module glyph_rom_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int MAX_STARVE = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  output logic              o_req0_ready,
  output logic              o_rsp0_valid,
  output logic [DATA_W-1:0] o_rsp0_data,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  output logic              o_req1_ready,
  output logic              o_rsp1_valid,
  output logic [DATA_W-1:0] o_rsp1_data,
  output logic              o_rom_en,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_starved
);

  localparam int CNT_W = $clog2(MAX_STARVE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STARVE);

  // S_FORCE means port 1 has priority for the current cycle.
  typedef enum logic {S_NORMAL, S_FORCE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               grant0, grant1, grant_any;

  logic               rom_en_q;
  logic [ADDR_W-1:0]  rom_addr_q;
  logic               tag1_vld_q, tag1_port_q;
  logic               tag2_vld_q, tag2_port_q;

  // Combinational arbitration: at most one grant per cycle.
  assign o_starved    = (state_q == S_FORCE);
  assign o_req0_ready = !o_starved;
  assign o_req1_ready = o_starved || !i_req0_valid;
  assign grant0       = i_req0_valid && o_req0_ready;
  assign grant1       = i_req1_valid && o_req1_ready;
  assign grant_any    = grant0 || grant1;

  assign o_rom_en     = rom_en_q;
  assign o_rom_addr   = rom_addr_q;

  // Starvation next-state: count port 1's consecutive lost cycles, force on reaching MAX_STARVE.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!i_req1_valid || grant1) begin
      state_d = S_NORMAL;
      cnt_d   = '0;
    end else if (state_q == S_NORMAL) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CNT_MAX) begin
        state_d = S_FORCE;
      end
    end
  end

  // Starvation state and counter registers.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      state_q <= S_NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read pipeline: drive ROM on grant, then carry the port tag alongside the ROM latency.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      tag1_vld_q  <= 1'b0;
      tag1_port_q <= 1'b0;
      tag2_vld_q  <= 1'b0;
      tag2_port_q <= 1'b0;
    end else begin
      rom_en_q    <= grant_any;
      if (grant_any) begin
        rom_addr_q <= grant1 ? i_req1_addr : i_req0_addr;
      end
      tag1_vld_q  <= grant_any;
      tag1_port_q <= grant1;
      tag2_vld_q  <= tag1_vld_q;
      tag2_port_q <= tag1_port_q;
    end
  end

  // Route the returned ROM row to the port that issued the read; the other port sees zeros.
  always_comb begin
    o_rsp0_valid = 1'b0;
    o_rsp0_data  = '0;
    o_rsp1_valid = 1'b0;
    o_rsp1_data  = '0;
    if (tag2_vld_q) begin
      if (tag2_port_q) begin
        o_rsp1_valid = 1'b1;
        o_rsp1_data  = i_rom_data;
      end else begin
        o_rsp0_valid = 1'b1;
        o_rsp0_data  = i_rom_data;
      end
    end
  end

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// Self-checking bench for glyph_rom_arbiter: a synchronous ROM model drives
// i_rom_data, a queue-based reference model predicts every output each cycle,
// and directed sequences pin a few hand-computed values.
module tb_glyph_rom_arbiter;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int MAX_STARVE = 4;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_req0_valid = 1'b0;
  logic [ADDR_W-1:0] i_req0_addr = '0;
  logic              o_req0_ready;
  logic              o_rsp0_valid;
  logic [DATA_W-1:0] o_rsp0_data;
  logic              i_req1_valid = 1'b0;
  logic [ADDR_W-1:0] i_req1_addr = '0;
  logic              o_req1_ready;
  logic              o_rsp1_valid;
  logic [DATA_W-1:0] o_rsp1_data;
  logic              o_rom_en;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [DATA_W-1:0] i_rom_data;
  logic              o_starved;

  int n_pass  = 0;
  int n_total = 0;

  glyph_rom_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_STARVE(MAX_STARVE)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req0_valid(i_req0_valid),
    .i_req0_addr (i_req0_addr),
    .o_req0_ready(o_req0_ready),
    .o_rsp0_valid(o_rsp0_valid),
    .o_rsp0_data (o_rsp0_data),
    .i_req1_valid(i_req1_valid),
    .i_req1_addr (i_req1_addr),
    .o_req1_ready(o_req1_ready),
    .o_rsp1_valid(o_rsp1_valid),
    .o_rsp1_data (o_rsp1_data),
    .o_rom_en    (o_rom_en),
    .o_rom_addr  (o_rom_addr),
    .i_rom_data  (i_rom_data),
    .o_starved   (o_starved)
  );

  always #5 i_clk = ~i_clk;

  // Glyph ROM contents: rom[a] = (a*37 + 5) mod 256.
  logic [DATA_W-1:0] rom [1<<ADDR_W];
  logic [DATA_W-1:0] rom_q = '0;
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = DATA_W'((i * 37 + 5) % 256);
  end

  // Synchronous-read ROM: data appears one clock after the sampling edge.
  always @(posedge i_clk) begin
    if (o_rom_en) rom_q <= rom[o_rom_addr];
  end
  assign i_rom_data = rom_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int                cyc_due;
    bit                port;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t              exp_q[$];
  int                cyc      = 0;
  int                lost     = 0;      // port 1's consecutive lost cycles
  bit                m_force  = 1'b0;   // port 1 has priority this cycle
  bit                m_en     = 1'b0;
  logic [ADDR_W-1:0] m_addr   = '0;

  always @(negedge i_clk) begin
    bit                e_r0, e_r1, g0, g1, e_v0, e_v1;
    logic [DATA_W-1:0] e_d0, e_d1;
    e_r0 = !m_force;
    e_r1 = m_force || !i_req0_valid;
    e_v0 = 1'b0; e_v1 = 1'b0; e_d0 = '0; e_d1 = '0;
    if (exp_q.size() > 0 && exp_q[0].cyc_due == cyc) begin
      if (exp_q[0].port) begin e_v1 = 1'b1; e_d1 = exp_q[0].data; end
      else               begin e_v0 = 1'b1; e_d0 = exp_q[0].data; end
      void'(exp_q.pop_front());
    end
    check("req0_ready", 32'(o_req0_ready), 32'(e_r0));
    check("req1_ready", 32'(o_req1_ready), 32'(e_r1));
    check("starved",    32'(o_starved),    32'(m_force));
    check("rom_en",     32'(o_rom_en),     32'(m_en));
    check("rom_addr",   32'(o_rom_addr),   32'(m_addr));
    check("rsp0_valid", 32'(o_rsp0_valid), 32'(e_v0));
    check("rsp0_data",  32'(o_rsp0_data),  32'(e_d0));
    check("rsp1_valid", 32'(o_rsp1_valid), 32'(e_v1));
    check("rsp1_data",  32'(o_rsp1_data),  32'(e_d1));

    if (i_rst) begin
      exp_q.delete();
      lost = 0; m_force = 1'b0; m_en = 1'b0; m_addr = '0;
    end else begin
      g0 = i_req0_valid && e_r0;
      g1 = i_req1_valid && e_r1;
      m_en = g0 || g1;
      if (g0) begin m_addr = i_req0_addr; exp_q.push_back('{cyc + 2, 1'b0, rom[i_req0_addr]}); end
      if (g1) begin m_addr = i_req1_addr; exp_q.push_back('{cyc + 2, 1'b1, rom[i_req1_addr]}); end
      if (!i_req1_valid || g1) begin
        lost = 0; m_force = 1'b0;
      end else if (!m_force) begin
        lost = (lost < MAX_STARVE) ? lost + 1 : lost;
        m_force = (lost == MAX_STARVE);
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input bit v0, input int a0, input bit v1, input int a1);
    i_req0_valid = v0; i_req0_addr = ADDR_W'(a0);
    i_req1_valid = v1; i_req1_addr = ADDR_W'(a1);
  endtask

  initial begin
    logic [19:0] pat20;
    logic [7:0]  pat8;
    int          cnt;

    // Power-on reset.
    next_cycle();
    next_cycle();
    i_rst = 1'b0;
    drive(0, 0, 0, 0);
    next_cycle();

    // Single read of 0x12: address visible after acceptance, data two clocks later.
    drive(1, 'h12, 0, 0);
    @(negedge i_clk);
    check("single_ready0", 32'(o_req0_ready), 32'd1);
    next_cycle();
    drive(0, 0, 0, 0);
    @(negedge i_clk);
    check("single_rom_en",   32'(o_rom_en),   32'd1);
    check("single_rom_addr", 32'(o_rom_addr), 32'h12);
    next_cycle();
    @(negedge i_clk);
    check("single_rsp0_valid", 32'(o_rsp0_valid), 32'd1);
    check("single_rsp0_data",  32'(o_rsp0_data),  32'h9F);
    check("single_rsp1_valid", 32'(o_rsp1_valid), 32'd0);
    next_cycle();

    // Back-to-back addresses 0..7 on port 0: eight response pulses.
    cnt = 0;
    for (int i = 0; i < 11; i++) begin
      drive(i < 8, i, 0, 0);
      @(negedge i_clk);
      if (o_rsp0_valid) cnt++;
      next_cycle();
    end
    check("b2b_rsp0_count", 32'(cnt), 32'd8);

    // Continuous contention: port 1 forced through every 5th cycle.
    for (int i = 0; i < 20; i++) begin
      drive(1, 'h20 + i, 1, 'h50 + i);
      @(negedge i_clk);
      pat20[i] = o_starved;
      next_cycle();
    end
    check("contention_starved_pattern", 32'(pat20), 32'h84210);
    drive(0, 0, 0, 0);
    next_cycle();
    next_cycle();

    // Interleave: alternating single-port requests, four responses each.
    cnt = 0;
    for (int i = 0; i < 11; i++) begin
      drive((i < 8) && (i % 2 == 0), 'h30 + i, (i < 8) && (i % 2 == 1), 'h60 + i);
      @(negedge i_clk);
      if (o_rsp1_valid) cnt++;
      next_cycle();
    end
    check("interleave_rsp1_count", 32'(cnt), 32'd4);

    // Withdraw: port 1 loses 3 cycles then drops; a new request counts from zero.
    for (int i = 0; i < 10; i++) begin
      drive(1, 'h10 + i, (i < 3) || (i >= 5), 'h70 + i);
      @(negedge i_clk);
      if (i >= 2) pat8[i-2] = o_starved;
      next_cycle();
    end
    check("withdraw_starved_pattern", 32'(pat8), 32'h80);
    drive(0, 0, 0, 0);
    next_cycle();

    // Randomized traffic with a reset pulse in the middle of the stream.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 127),
            $urandom_range(0, 2) != 0, $urandom_range(0, 127));
      if (i == 300) begin
        i_rst = 1'b1;
        next_cycle();
        next_cycle();
        i_rst = 1'b0;
        drive(0, 0, 0, 0);
        @(negedge i_clk);
        check("reset_rom_en",     32'(o_rom_en),     32'd0);
        check("reset_rom_addr",   32'(o_rom_addr),   32'd0);
        check("reset_rsp0_valid", 32'(o_rsp0_valid), 32'd0);
        check("reset_rsp1_valid", 32'(o_rsp1_valid), 32'd0);
        check("reset_starved",    32'(o_starved),    32'd0);
      end
      next_cycle();
    end

    drive(0, 0, 0, 0);
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
